mem_stage_sram: RTL and testbench

MEM_STAGE_SRAM -- requirements
Module: mem_stage_sram

---
 rtl/mem_stage_sram.sv | 119 +++++++++++
 tb/tb_mem_stage_sram.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_sram.sv
// Memory stage that splits each 32-bit load/store into two 16-bit SRAM
// accesses, stalling the pipeline until both halves complete.
module mem_stage_sram #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_en_in,
    input  logic        mem_read_en_in,
    input  logic        mem_write_en_in,
    input  logic [31:0] alu_res_in,
    input  logic [31:0] val_Rm_in,
    input  logic [3:0]  dest_in,
    input  logic [15:0] sram_rdata,
    output logic        wb_en,
    output logic        mem_read_en,
    output logic [31:0] alu_res,
    output logic [3:0]  dest,
    output logic [31:0] mem_data,
    output logic        freeze,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_wdata,
    output logic        sram_we_n,
    output logic        sram_oe_n
);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] lo_q, lo_d;
    logic [31:0] mem_data_q, mem_data_d;

    logic        req, rd, wr, last, active, idle_eff;
    logic [16:0] word;

    assign req  = mem_read_en_in | mem_write_en_in;
    assign rd   = mem_read_en_in;
    assign wr   = mem_write_en_in & ~mem_read_en_in;
    assign last = (cnt_q == LAST);
    assign word = 17'((alu_res_in - 32'd1024) >> 2);

    assign wb_en       = wb_en_in;
    assign mem_read_en = mem_read_en_in;
    assign alu_res     = alu_res_in;
    assign dest        = dest_in;
    assign mem_data    = mem_data_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lo_d       = lo_q;
        mem_data_d = mem_data_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = LO;
                    cnt_d   = 4'd0;
                end
            end
            LO: begin
                if (last) begin
                    state_d = HI;
                    cnt_d   = 4'd0;
                    if (rd) lo_d = sram_rdata;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            HI: begin
                if (last) begin
                    state_d = DONE;
                    cnt_d   = 4'd0;
                    if (rd) mem_data_d = {sram_rdata, lo_q};
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // While reset is held the stall behaves as if already back in IDLE.
    always_comb begin
        active   = (state_q == LO) || (state_q == HI);
        idle_eff = !rst || (state_q == IDLE);
        freeze   = (rst && active) || (idle_eff && req);
        sram_addr  = 18'd0;
        sram_wdata = 16'd0;
        sram_we_n  = 1'b1;
        sram_oe_n  = 1'b1;
        if (active) begin
            sram_addr = {word, state_q == HI};
            sram_we_n = ~wr;
            sram_oe_n = ~rd;
            if (wr) begin
                sram_wdata = (state_q == HI) ? val_Rm_in[31:16] : val_Rm_in[15:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            lo_q       <= 16'd0;
            mem_data_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lo_q       <= lo_d;
            mem_data_q <= mem_data_d;
        end
    end

endmodule

// File: tb/tb_mem_stage_sram.sv
// Directed bench for mem_stage_sram with a behavioural 16-bit SRAM model.
module tb_mem_stage_sram;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_en_in, mem_read_en_in, mem_write_en_in;
    logic [31:0] alu_res_in, val_Rm_in;
    logic [3:0]  dest_in;
    logic [15:0] sram_rdata;
    logic        wb_en, mem_read_en, freeze, sram_we_n, sram_oe_n;
    logic [31:0] alu_res, mem_data;
    logic [3:0]  dest;
    logic [17:0] sram_addr;
    logic [15:0] sram_wdata;

    int pass_cnt = 0;
    int total    = 0;

    logic [15:0] sram [0:511];

    always #5 clk = ~clk;

    mem_stage_sram #(.WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst),
        .wb_en_in(wb_en_in), .mem_read_en_in(mem_read_en_in),
        .mem_write_en_in(mem_write_en_in), .alu_res_in(alu_res_in),
        .val_Rm_in(val_Rm_in), .dest_in(dest_in), .sram_rdata(sram_rdata),
        .wb_en(wb_en), .mem_read_en(mem_read_en), .alu_res(alu_res),
        .dest(dest), .mem_data(mem_data), .freeze(freeze),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
    );

    always @(posedge clk) begin
        if (!sram_we_n) sram[sram_addr[8:0]] <= sram_wdata;
    end

    assign sram_rdata = sram_oe_n ? 16'h0 : sram[sram_addr[8:0]];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else pass_cnt++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_read_en_in  = 1'b0;
        mem_write_en_in = 1'b0;
        alu_res_in      = 32'd0;
        val_Rm_in       = 32'd0;
    endtask

    // Runs one access from IDLE and leaves the bench in its DONE cycle.
    task automatic run_access(input string nm, input logic rdi, input logic wri,
                              input logic [31:0] a, input logic [31:0] v,
                              input logic [31:0] md);
        logic        wo;
        logic [16:0] w;
        logic [17:0] ea;
        logic [15:0] ed;
        wo = wri & ~rdi;
        w  = 17'((a - 32'd1024) >> 2);
        mem_read_en_in  = rdi;
        mem_write_en_in = wri;
        alu_res_in      = a;
        val_Rm_in       = v;
        #1;
        for (int k = 0; k <= 2 * W; k++) begin
            ea = (k == 0) ? 18'd0 : {w, k > W};
            chk({nm, " freeze"}, 32'(freeze), 32'd1);
            chk({nm, " addr"}, 32'(sram_addr), 32'(ea));
            chk({nm, " we_n"}, 32'(sram_we_n), 32'((k > 0 && wo) ? 1'b0 : 1'b1));
            chk({nm, " oe_n"}, 32'(sram_oe_n), 32'((k > 0 && rdi) ? 1'b0 : 1'b1));
            if (wo && k > 0) begin
                ed = (k > W) ? v[31:16] : v[15:0];
                chk({nm, " wdata"}, 32'(sram_wdata), 32'(ed));
            end
            tick();
        end
        chk({nm, " done freeze"}, 32'(freeze), 32'd0);
        chk({nm, " done strobes"}, 32'({sram_we_n, sram_oe_n}), 32'd3);
        chk({nm, " done addr"}, 32'(sram_addr), 32'd0);
        chk({nm, " mem_data"}, mem_data, md);
    endtask

    typedef struct {
        logic        wb;
        logic        rd;
        logic        wr;
        logic [31:0] alu;
        logic [3:0]  dst;
        logic        frz;
    } rst_vec_t;

    typedef struct {
        logic        frz;
        logic [17:0] addr;
        logic [15:0] wd;
        logic        we_n;
        logic        oe_n;
    } wr_vec_t;

    rst_vec_t rv [4];
    wr_vec_t  wv [6];

    initial begin
        for (int i = 0; i < 512; i++) sram[i] = 16'h0;
        rv[0] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 4'h0, 1'b0};
        rv[1] = '{1'b1, 1'b1, 1'b0, 32'h0000_0408, 4'h5, 1'b1};
        rv[2] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 4'hF, 1'b1};
        rv[3] = '{1'b1, 1'b1, 1'b1, 32'h1234_5678, 4'hA, 1'b1};
        wv[0] = '{1'b1, 18'd0, 16'h0000, 1'b1, 1'b1};
        wv[1] = '{1'b1, 18'd4, 16'hBEEF, 1'b0, 1'b1};
        wv[2] = '{1'b1, 18'd4, 16'hBEEF, 1'b0, 1'b1};
        wv[3] = '{1'b1, 18'd5, 16'hDEAD, 1'b0, 1'b1};
        wv[4] = '{1'b1, 18'd5, 16'hDEAD, 1'b0, 1'b1};
        wv[5] = '{1'b0, 18'd0, 16'h0000, 1'b1, 1'b1};

        rst = 1'b0;
        wb_en_in = 1'b0;
        dest_in  = 4'h0;
        idle_inputs();
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            wb_en_in        = rv[i].wb;
            mem_read_en_in  = rv[i].rd;
            mem_write_en_in = rv[i].wr;
            alu_res_in      = rv[i].alu;
            dest_in         = rv[i].dst;
            #1;
            chk("rst freeze", 32'(freeze), 32'(rv[i].frz));
            chk("rst wb_en", 32'(wb_en), 32'(rv[i].wb));
            chk("rst mem_read_en", 32'(mem_read_en), 32'(rv[i].rd));
            chk("rst alu_res", alu_res, rv[i].alu);
            chk("rst dest", 32'(dest), 32'(rv[i].dst));
            chk("rst strobes", 32'({sram_we_n, sram_oe_n}), 32'd3);
            tick();
        end
        chk("rst mem_data", mem_data, 32'd0);
        idle_inputs();
        rst = 1'b1;
        tick();

        mem_write_en_in = 1'b1;
        alu_res_in      = 32'd1032;
        val_Rm_in       = 32'hDEAD_BEEF;
        #1;
        for (int i = 0; i < 6; i++) begin
            chk("wr freeze", 32'(freeze), 32'(wv[i].frz));
            chk("wr addr", 32'(sram_addr), 32'(wv[i].addr));
            chk("wr wdata", 32'(sram_wdata), 32'(wv[i].wd));
            chk("wr we_n", 32'(sram_we_n), 32'(wv[i].we_n));
            chk("wr oe_n", 32'(sram_oe_n), 32'(wv[i].oe_n));
            if (i == 5) idle_inputs();
            tick();
        end

        for (int i = 0; i < 10; i++) begin
            chk("idle freeze", 32'(freeze), 32'd0);
            chk("idle strobes", 32'({sram_we_n, sram_oe_n}), 32'd3);
            chk("idle addr", 32'(sram_addr), 32'd0);
            chk("idle mem_data", mem_data, 32'd0);
            tick();
        end

        run_access("rd", 1'b1, 1'b0, 32'd1032, 32'h0, 32'hDEAD_BEEF);
        idle_inputs();
        tick();

        run_access("both", 1'b1, 1'b1, 32'd1032, 32'h5555_AAAA, 32'hDEAD_BEEF);
        idle_inputs();
        tick();

        run_access("b2b wr", 1'b0, 1'b1, 32'd1040, 32'h1234_5678, 32'hDEAD_BEEF);
        mem_read_en_in  = 1'b1;
        mem_write_en_in = 1'b0;
        tick();
        run_access("b2b rd", 1'b1, 1'b0, 32'd1040, 32'h0, 32'h1234_5678);
        idle_inputs();
        tick();

        mem_read_en_in = 1'b1;
        alu_res_in     = 32'd1032;
        #1;
        for (int k = 0; k < 4; k++) tick();
        chk("mid hi addr", 32'(sram_addr), 32'd5);
        rst = 1'b0;
        tick();
        chk("mid rst freeze", 32'(freeze), 32'd1);
        chk("mid rst strobes", 32'({sram_we_n, sram_oe_n}), 32'd3);
        chk("mid rst addr", 32'(sram_addr), 32'd0);
        chk("mid rst mem_data", mem_data, 32'd0);
        idle_inputs();
        #1;
        chk("mid rst freeze idle", 32'(freeze), 32'd0);
        rst = 1'b1;
        tick();
        chk("post rst strobes", 32'({sram_we_n, sram_oe_n}), 32'd3);
        chk("post rst mem_data", mem_data, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
